// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants, state encoding and digit-code helper for the seven-segment scan scheduler.
package seg_scan_ctrl_pkg;

  localparam logic [4:0] SYMBOL_CODE   = 5'h10;
  localparam int         NUM_DIGITS    = 8;
  localparam logic [7:0] BLANK_DIG_SEL = 8'h00;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_BLANK_ENC = 2'd1;
  localparam logic [1:0] ST_SHOW_ENC  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE_ENC,
    BLANK = ST_BLANK_ENC,
    SHOW  = ST_SHOW_ENC
  } scan_state_e;

  // Code handed to hex_seg7 for one digit of an image: nibble or the symbol code.
  function automatic logic [4:0] digit_code(input logic [31:0] data,
                                            input logic [7:0]  mask,
                                            input logic [2:0]  idx);
    logic [3:0] nib;
    nib = data[{idx, 2'b00} +: 4];
    return mask[idx] ? SYMBOL_CODE : {1'b0, nib};
  endfunction

endpackage

// File: rtl/seg_prescaler.sv
// Slot-time counter: counts 0..CLK_DIV-1 and strobes the last cycle of the slot and of its blanking window.
module seg_prescaler #(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic clk,
  input  logic rtsn,
  input  logic clr,
  output logic tc,
  output logic blank_end
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  logic [CNT_W-1:0] cnt;

  assign tc        = (cnt == CNT_LAST);
  // With BLANK_CYC = 0 there is no blanking window, so the strobe never fires.
  assign blank_end = (BLANK_CYC != 0) && (cnt == BLANK_LAST);

  always_ff @(posedge clk) begin
    if (!rtsn || clr) begin
      cnt <= '0;
    end else if (tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit scan scheduler: digit sequencing with per-slot blanking and a
// double-buffered display image that is swapped only at frame boundaries.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rtsn,
  input  logic        enable,
  input  logic        upd_valid,
  input  logic [31:0] upd_data,
  input  logic [7:0]  upd_symmask,
  output logic        upd_ready,
  output logic [7:0]  dig_sel,
  output logic [4:0]  dig_code,
  output logic        frame_done,
  output scan_state_e dbg_state
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam scan_state_e SLOT_FIRST = (BLANK_CYC == 0) ? SHOW : BLANK;

  scan_state_e      state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             tc, blank_end, cnt_clr, slot_wrap, slot_start;
  logic             xfer, swap, pend_full;
  logic [31:0]      act_data, act_data_nxt, pend_data;
  logic [7:0]       act_mask, act_mask_nxt, pend_mask;

  seg_prescaler #(
    .CLK_DIV   (CLK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_prescaler (
    .clk       (clk),
    .rtsn      (rtsn),
    .clr       (cnt_clr),
    .tc        (tc),
    .blank_end (blank_end)
  );

  // Update handshake: a transfer happens on any posedge where upd_valid && upd_ready;
  // upd_ready is high exactly while the pending buffer is empty, and the source
  // must hold upd_valid and its data stable until that transfer edge.
  assign upd_ready  = !pend_full;
  assign xfer       = upd_valid && upd_ready;

  assign cnt_clr    = (state == IDLE) || !enable;
  assign slot_wrap  = (state != IDLE) && tc;
  assign frame_done = slot_wrap && (idx == LAST_IDX);
  assign dbg_state  = state;

  // xfer and swap are mutually exclusive: a transfer needs an empty pending buffer.
  assign swap         = pend_full && (frame_done || (state == IDLE));
  assign act_data_nxt = swap ? pend_data : act_data;
  assign act_mask_nxt = swap ? pend_mask : act_mask;

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    slot_start = 1'b0;
    dig_sel    = BLANK_DIG_SEL;
    if (state == SHOW) begin
      dig_sel = 8'h80 >> idx;
    end
    if (!enable) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt  = SLOT_FIRST;
          idx_nxt    = '0;
          slot_start = 1'b1;
        end
        BLANK: begin
          if (blank_end) state_nxt = SHOW;
        end
        SHOW: begin
          if (slot_wrap) begin
            state_nxt  = SLOT_FIRST;
            idx_nxt    = idx + 1'b1;
            slot_start = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rtsn) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // The next slot's code is taken from the post-swap image so digit 0 of a new frame is already new.
  always_ff @(posedge clk) begin
    if (!rtsn) begin
      dig_code  <= SYMBOL_CODE;
      act_data  <= '0;
      act_mask  <= 8'hFF;
      pend_data <= '0;
      pend_mask <= '0;
      pend_full <= 1'b0;
    end else begin
      act_data <= act_data_nxt;
      act_mask <= act_mask_nxt;
      if (slot_start) begin
        dig_code <= digit_code(act_data_nxt, act_mask_nxt, idx_nxt);
      end
      if (xfer) begin
        pend_data <= upd_data;
        pend_mask <= upd_symmask;
        pend_full <= 1'b1;
      end else if (swap) begin
        pend_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: one instance with blanking, one without.
module tb_seg_scan_ctrl;
  import seg_scan_ctrl_pkg::*;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rtsn, a_enable, a_upd_valid, a_upd_ready, a_frame_done;
  logic [31:0] a_upd_data;
  logic [7:0]  a_upd_symmask, a_dig_sel;
  logic [4:0]  a_dig_code;
  scan_state_e a_dbg_state;

  logic        b_rtsn, b_enable, b_upd_valid, b_upd_ready, b_frame_done;
  logic [31:0] b_upd_data;
  logic [7:0]  b_upd_symmask, b_dig_sel;
  logic [4:0]  b_dig_code;
  scan_state_e b_dbg_state;

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl #(.CLK_DIV(8), .BLANK_CYC(2)) u_dut_a (
    .clk(clk), .rtsn(a_rtsn), .enable(a_enable), .upd_valid(a_upd_valid),
    .upd_data(a_upd_data), .upd_symmask(a_upd_symmask), .upd_ready(a_upd_ready),
    .dig_sel(a_dig_sel), .dig_code(a_dig_code), .frame_done(a_frame_done),
    .dbg_state(a_dbg_state)
  );

  seg_scan_ctrl #(.CLK_DIV(8), .BLANK_CYC(0)) u_dut_b (
    .clk(clk), .rtsn(b_rtsn), .enable(b_enable), .upd_valid(b_upd_valid),
    .upd_data(b_upd_data), .upd_symmask(b_upd_symmask), .upd_ready(b_upd_ready),
    .dig_sel(b_dig_sel), .dig_code(b_dig_code), .frame_done(b_frame_done),
    .dbg_state(b_dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] pk(input logic [4:0] c0, input logic [4:0] c1,
                                     input logic [4:0] c2, input logic [4:0] c3,
                                     input logic [4:0] c4, input logic [4:0] c5,
                                     input logic [4:0] c6, input logic [4:0] c7);
    return {c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  // driver task
  task automatic drive(input bit sel, input logic v, input logic [31:0] d, input logic [7:0] m);
    if (sel) begin
      b_upd_valid = v; b_upd_data = d; b_upd_symmask = m;
    end else begin
      a_upd_valid = v; a_upd_data = d; a_upd_symmask = m;
    end
  endtask

  // Steps through n_cyc cycles of a frame (CLK_DIV = 8) starting at slot 0, cnt 0,
  // checking every cycle; offers/switches/drops the update at the given cycles.
  // upd_ready is expected low for cycles nr_from..nr_to of this frame.
  task automatic run_frame(input bit sel, input string name, input logic [39:0] codes,
                           input int blank, input int n_cyc,
                           input int off_c, input logic [31:0] d0, input logic [7:0] m0,
                           input int sw_c, input logic [31:0] d1, input logic [7:0] m1,
                           input int drop_c, input int nr_from, input int nr_to);
    logic        v;
    logic [31:0] d;
    logic [7:0]  m;
    v = sel ? b_upd_valid : a_upd_valid;
    d = sel ? b_upd_data : a_upd_data;
    m = sel ? b_upd_symmask : a_upd_symmask;
    for (int c = 0; c < n_cyc; c++) begin
      int slot;
      int cn;
      logic [7:0] e_sel;
      slot  = c / 8;
      cn    = c % 8;
      e_sel = (cn < blank) ? 8'h00 : (8'h80 >> slot);
      chk($sformatf("%s dig_sel c%0d", name, c), sel ? b_dig_sel : a_dig_sel, e_sel);
      chk($sformatf("%s dig_code c%0d", name, c), 8'(sel ? b_dig_code : a_dig_code),
          8'(codes[5*slot +: 5]));
      chk($sformatf("%s frame_done c%0d", name, c), 8'(sel ? b_frame_done : a_frame_done),
          8'(c == 63));
      chk($sformatf("%s upd_ready c%0d", name, c), 8'(sel ? b_upd_ready : a_upd_ready),
          8'(!(c >= nr_from && c <= nr_to)));
      if (c == off_c) begin v = 1'b1; d = d0; m = m0; end
      if (c == sw_c) begin d = d1; m = m1; end
      if (c == drop_c) v = 1'b0;
      drive(sel, v, d, m);
      tick();
    end
  endtask

  logic [39:0] all_sym, codes_1, codes_a, codes_b, codes_c, codes_d;

  initial begin
    all_sym = {8{5'h10}};
    codes_1 = pk(5'h01, 5'h02, 5'h10, 5'h10, 5'h05, 5'h06, 5'h07, 5'h08);
    codes_a = pk(5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h0F);
    codes_b = pk(5'h00, 5'h00, 5'h00, 5'h00, 5'h10, 5'h10, 5'h10, 5'h10);
    codes_c = pk(5'h10, 5'h0D, 5'h0B, 5'h09, 5'h07, 5'h05, 5'h03, 5'h10);
    codes_d = pk(5'h0A, 5'h05, 5'h0A, 5'h05, 5'h05, 5'h0A, 5'h05, 5'h0A);

    a_rtsn = 1'b0; a_enable = 1'b0; a_upd_valid = 1'b0; a_upd_data = '0; a_upd_symmask = '0;
    b_rtsn = 1'b0; b_enable = 1'b0; b_upd_valid = 1'b0; b_upd_data = '0; b_upd_symmask = '0;
    repeat (3) tick();

    // reset state
    chk("rst dig_sel", a_dig_sel, 8'h00);
    chk("rst dig_code", 8'(a_dig_code), 8'h10);
    chk("rst frame_done", 8'(a_frame_done), 8'h00);
    chk("rst upd_ready", 8'(a_upd_ready), 8'h01);
    chk("rst state", 8'(a_dbg_state), 8'(IDLE));

    // frame 0: default symbols; image loaded mid-frame, held until the frame end
    a_rtsn = 1'b1; a_enable = 1'b1;
    tick();
    chk("start state", 8'(a_dbg_state), 8'(BLANK));
    run_frame(0, "f0", all_sym, 2, 64, 20, 32'h8765_4321, 8'h0C, -1, '0, '0, 21, 21, 63);

    // frame 1: new image; back-pressure with A then B offered
    run_frame(0, "f1", codes_1, 2, 64, 10, 32'hFEDC_BA98, 8'h00, 11, 32'h0000_0000, 8'hF0,
              -1, 11, 63);
    // frame 2: A shown; B accepted on the cycle after the swap
    run_frame(0, "f2", codes_a, 2, 64, -1, '0, '0, -1, '0, '0, 1, 1, 63);
    run_frame(0, "f3", codes_b, 2, 64, -1, '0, '0, -1, '0, '0, -1, 64, -1);

    // frame 4: offer on the frame_done cycle with pending empty -> no swap this frame
    run_frame(0, "f4", codes_b, 2, 64, 63, 32'h1357_9BDF, 8'h81, -1, '0, '0, -1, 64, -1);
    run_frame(0, "f5", codes_b, 2, 64, -1, '0, '0, -1, '0, '0, 0, 0, 63);
    run_frame(0, "f6", codes_c, 2, 64, -1, '0, '0, -1, '0, '0, -1, 64, -1);

    // enable drop mid-slot at digit 3
    run_frame(0, "f7", codes_c, 2, 28, -1, '0, '0, -1, '0, '0, -1, 64, -1);
    chk("mid idx3 dig_sel", a_dig_sel, 8'h10);
    a_enable = 1'b0;
    tick();
    chk("drop dig_sel", a_dig_sel, 8'h00);
    chk("drop frame_done", 8'(a_frame_done), 8'h00);
    chk("drop state", 8'(a_dbg_state), 8'(IDLE));
    drive(0, 1'b1, 32'hA5A5_5A5A, 8'h00);
    tick();
    chk("idle xfer ready", 8'(a_upd_ready), 8'h00);
    drive(0, 1'b0, 32'hA5A5_5A5A, 8'h00);
    tick();
    chk("idle swap ready", 8'(a_upd_ready), 8'h01);
    a_enable = 1'b1;
    tick();
    chk("reen state", 8'(a_dbg_state), 8'(BLANK));
    run_frame(0, "f8", codes_d, 2, 64, -1, '0, '0, -1, '0, '0, -1, 64, -1);

    // enable falls on the frame_done cycle: pulse still seen and the swap completes
    run_frame(0, "f9", codes_d, 2, 63, 5, 32'h0000_000C, 8'h00, -1, '0, '0, 6, 6, 63);
    chk("fd drop frame_done", 8'(a_frame_done), 8'h01);
    chk("fd drop ready", 8'(a_upd_ready), 8'h00);
    a_enable = 1'b0;
    tick();
    chk("fd drop swap ready", 8'(a_upd_ready), 8'h01);
    chk("fd drop dig_sel", a_dig_sel, 8'h00);
    a_enable = 1'b1;
    tick();
    chk("fd drop new code", 8'(a_dig_code), 8'h0C);
    chk("fd drop blank", a_dig_sel, 8'h00);

    // no-blanking instance: every cycle shows a digit; reset at slot 5 drops pending
    b_rtsn = 1'b1; b_enable = 1'b1;
    tick();
    chk("b start state", 8'(b_dbg_state), 8'(SHOW));
    run_frame(1, "b0", all_sym, 0, 43, 3, 32'h1234_5678, 8'h00, -1, '0, '0, 4, 4, 63);
    chk("b idx5 dig_sel", b_dig_sel, 8'h04);
    b_rtsn = 1'b0;
    tick();
    chk("b rst dig_sel", b_dig_sel, 8'h00);
    chk("b rst ready", 8'(b_upd_ready), 8'h01);
    chk("b rst dig_code", 8'(b_dig_code), 8'h10);
    chk("b rst frame_done", 8'(b_frame_done), 8'h00);
    b_rtsn = 1'b1;
    tick();
    run_frame(1, "b1", all_sym, 0, 64, -1, '0, '0, -1, '0, '0, -1, 64, -1);
    chk("b no phantom swap", 8'(b_dig_code), 8'h10);
    chk("b wrap dig_sel", b_dig_sel, 8'h80);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
